// File: rtl/i2c_target_regs_pkg.sv
// ============================================================================
// Module : i2c_target_regs_pkg
// Brief  : Shared types and constants for the I2C register-file target.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package i2c_target_regs_pkg;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        ADDR   = 4'd1,
        A_ACK  = 4'd2,
        PTR    = 4'd3,
        P_ACK  = 4'd4,
        WR     = 4'd5,
        W_ACK  = 4'd6,
        RD     = 4'd7,
        R_ACK  = 4'd8,
        IGNORE = 4'd9
    } state_t;

    localparam logic I2C_ACK     = 1'b0;
    localparam logic I2C_NACK    = 1'b1;
    localparam int   SYNC_STAGES = 2;

    function automatic logic addr_match(input logic [7:0] addr_byte,
                                        input logic [6:0] dev_addr);
        return addr_byte[7:1] == dev_addr;
    endfunction

endpackage

`default_nettype wire

// File: rtl/i2c_target_regs_if.sv
// ============================================================================
// Module : i2c_target_regs_if
// Brief  : Open-drain I2C bus pins seen by the target (SCL in, SDA in/pull-down).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface i2c_target_regs_if;
    logic scl_in;
    logic sda_in;
    logic sda_oe;

    modport master (output scl_in, output sda_in, input  sda_oe);
    modport slave  (input  scl_in, input  sda_in, output sda_oe);
endinterface

`default_nettype wire

// File: rtl/i2c_target_regs_bus_sync.sv
// ============================================================================
// Module : i2c_bus_sync
// Brief  : SCL/SDA synchronisers with SCL edge and START/STOP condition pulses.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module i2c_bus_sync
    import i2c_target_regs_pkg::*;
(
    input  wire logic clk,
    input  wire logic nrst,
    input  wire logic i_scl,
    input  wire logic i_sda,
    output logic      o_sda,
    output logic      o_scl_rise,
    output logic      o_scl_fall,
    output logic      o_start,
    output logic      o_stop
);

    // Chains reset to the idle-bus level so reset release never looks like an edge
    logic [SYNC_STAGES:0] r_scl;
    logic [SYNC_STAGES:0] r_sda;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_scl <= '1;
            r_sda <= '1;
        end else begin
            r_scl <= {r_scl[SYNC_STAGES-1:0], i_scl};
            r_sda <= {r_sda[SYNC_STAGES-1:0], i_sda};
        end
    end

    logic w_scl_s, w_scl_d, w_sda_s, w_sda_d;

    assign w_scl_s = r_scl[SYNC_STAGES-1];
    assign w_scl_d = r_scl[SYNC_STAGES];
    assign w_sda_s = r_sda[SYNC_STAGES-1];
    assign w_sda_d = r_sda[SYNC_STAGES];

    assign o_sda      = w_sda_s;
    assign o_scl_rise =  w_scl_s & ~w_scl_d;
    assign o_scl_fall = ~w_scl_s &  w_scl_d;
    assign o_start    =  w_scl_s &  w_scl_d & ~w_sda_s &  w_sda_d;
    assign o_stop     =  w_scl_s &  w_scl_d &  w_sda_s & ~w_sda_d;

endmodule

`default_nettype wire

// File: rtl/i2c_target_regs.sv
// ============================================================================
// Module : i2c_target_regs
// Brief  : I2C target with an auto-incrementing pointer into an NREG x 8 register file.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module i2c_target_regs
    import i2c_target_regs_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = 7'h50,
    parameter int         NREG     = 8,
    localparam int        PW       = $clog2(NREG)
) (
    input  wire logic          clk,
    input  wire logic          nrst,
    i2c_target_regs_if.slave   bus,
    output logic               o_wr_stb,
    output logic [PW-1:0]      o_wr_addr,
    output logic [7:0]         o_wr_data,
    input  wire logic [PW-1:0] i_loc_addr,
    output logic [7:0]         o_loc_rdata,
    output logic               o_busy
);

    logic w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;

    i2c_bus_sync u_sync (
        .clk        (clk),
        .nrst       (nrst),
        .i_scl      (bus.scl_in),
        .i_sda      (bus.sda_in),
        .o_sda      (w_sda),
        .o_scl_rise (w_scl_rise),
        .o_scl_fall (w_scl_fall),
        .o_start    (w_start),
        .o_stop     (w_stop)
    );

    state_t         r_state;
    logic [6:0]     r_shift;
    logic [3:0]     r_bitcnt;
    logic           r_phase;
    logic           r_rw;
    logic [PW-1:0]  r_ptr;
    logic [7:0]     r_regs [NREG];
    logic           r_sda_oe;
    logic           r_busy;
    logic           r_wr_stb;
    logic [PW-1:0]  r_wr_addr;
    logic [7:0]     r_wr_data;
    logic [7:0]     r_loc_rdata;

    logic [7:0]     w_byte;
    logic [7:0]     w_rd_byte;
    logic           w_shift_en;
    logic           w_byte_done;

    assign w_byte      = {r_shift, w_sda};
    assign w_rd_byte   = r_regs[r_ptr];
    assign w_shift_en  = w_scl_rise &&
                         (r_state == ADDR || r_state == PTR || r_state == WR);
    assign w_byte_done = w_shift_en && (r_bitcnt == 4'd7);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bitcnt  <= '0;
            r_phase   <= 1'b0;
            r_rw      <= 1'b0;
            r_ptr     <= '0;
            r_sda_oe  <= 1'b0;
            r_busy    <= 1'b0;
            r_wr_stb  <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_wr_stb <= 1'b0;
            if (w_start) begin
                r_state  <= ADDR;
                r_bitcnt <= '0;
                r_phase  <= 1'b0;
                r_sda_oe <= 1'b0;
            end else if (w_stop) begin
                r_state  <= IDLE;
                r_bitcnt <= '0;
                r_phase  <= 1'b0;
                r_sda_oe <= 1'b0;
                r_busy   <= 1'b0;
            end else begin
                if (w_shift_en) begin
                    r_shift  <= w_byte[6:0];
                    r_bitcnt <= r_bitcnt + 4'd1;
                end
                case (r_state)
                    ADDR: begin
                        if (w_byte_done) begin
                            r_bitcnt <= '0;
                            r_phase  <= 1'b0;
                            if (addr_match(w_byte, DEV_ADDR)) begin
                                r_rw    <= w_byte[0];
                                r_busy  <= 1'b1;
                                r_state <= A_ACK;
                            end else begin
                                r_busy  <= 1'b0;
                                r_state <= IGNORE;
                            end
                        end
                    end
                    PTR: begin
                        if (w_byte_done) begin
                            r_bitcnt <= '0;
                            r_phase  <= 1'b0;
                            r_ptr    <= w_byte[PW-1:0];
                            r_state  <= P_ACK;
                        end
                    end
                    WR: begin
                        if (w_byte_done) begin
                            r_bitcnt      <= '0;
                            r_phase       <= 1'b0;
                            r_regs[r_ptr] <= w_byte;
                            r_wr_stb      <= 1'b1;
                            r_wr_addr     <= r_ptr;
                            r_wr_data     <= w_byte;
                            r_ptr         <= r_ptr + 1'b1;
                            r_state       <= W_ACK;
                        end
                    end
                    // Phase 0: drive ACK after bit 8's fall; phase 1: hand over after the 9th fall
                    A_ACK, P_ACK, W_ACK: begin
                        if (w_scl_fall) begin
                            if (!r_phase) begin
                                r_sda_oe <= ~I2C_ACK;
                                r_phase  <= 1'b1;
                            end else begin
                                r_phase  <= 1'b0;
                                r_bitcnt <= '0;
                                if (r_state == A_ACK && r_rw) begin
                                    r_sda_oe <= ~w_rd_byte[7];
                                    r_state  <= RD;
                                end else begin
                                    r_sda_oe <= 1'b0;
                                    r_state  <= (r_state == A_ACK) ? PTR : WR;
                                end
                            end
                        end
                    end
                    RD: begin
                        if (w_scl_rise) begin
                            r_bitcnt <= r_bitcnt + 4'd1;
                        end else if (w_scl_fall) begin
                            if (r_bitcnt == 4'd8) begin
                                r_sda_oe <= 1'b0;
                                r_bitcnt <= '0;
                                r_phase  <= 1'b0;
                                r_state  <= R_ACK;
                            end else begin
                                r_sda_oe <= ~w_rd_byte[3'd7 - r_bitcnt[2:0]];
                            end
                        end
                    end
                    R_ACK: begin
                        if (w_scl_rise && !r_phase) begin
                            if (w_sda == I2C_NACK) begin
                                r_busy  <= 1'b0;
                                r_state <= IGNORE;
                            end else begin
                                r_ptr   <= r_ptr + 1'b1;
                                r_phase <= 1'b1;
                            end
                        end else if (w_scl_fall && r_phase) begin
                            r_phase  <= 1'b0;
                            r_bitcnt <= '0;
                            r_sda_oe <= ~w_rd_byte[7];
                            r_state  <= RD;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Same-cycle write to i_loc_addr returns the pre-write value (NBA ordering)
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_loc_rdata <= '0;
        end else begin
            r_loc_rdata <= r_regs[i_loc_addr];
        end
    end

    assign bus.sda_oe  = r_sda_oe;
    assign o_wr_stb    = r_wr_stb;
    assign o_wr_addr   = r_wr_addr;
    assign o_wr_data   = r_wr_data;
    assign o_loc_rdata = r_loc_rdata;
    assign o_busy      = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_i2c_target_regs.sv
// ============================================================================
// Module : tb_i2c_target_regs
// Brief  : Directed bus-master bench for i2c_target_regs with hand-computed expectations.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_i2c_target_regs;

    localparam int NREG = 8;
    localparam int PW   = 3;
    localparam int QTR  = 8;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    i2c_target_regs_if bus_if();

    logic          m_scl = 1'b1;
    logic          m_sda = 1'b1;
    logic          wr_stb;
    logic [PW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic [PW-1:0] loc_addr = '0;
    logic [7:0]    loc_rdata;
    logic          busy;

    assign bus_if.scl_in = m_scl;
    assign bus_if.sda_in = m_sda & ~bus_if.sda_oe;

    i2c_target_regs #(.DEV_ADDR(7'h50), .NREG(NREG)) dut (
        .clk         (clk),
        .nrst        (nrst),
        .bus         (bus_if),
        .o_wr_stb    (wr_stb),
        .o_wr_addr   (wr_addr),
        .o_wr_data   (wr_data),
        .i_loc_addr  (loc_addr),
        .o_loc_rdata (loc_rdata),
        .o_busy      (busy)
    );

    int total = 0;
    int bad   = 0;

    int            stb_cnt     = 0;
    logic [PW-1:0] stb_addr    = '0;
    logic [7:0]    stb_data    = '0;
    int            oe_high_cnt = 0;
    int            oe_glitch   = 0;
    bit            glitch_en   = 1'b1;
    logic          prev_scl    = 1'b1;
    logic          prev_oe     = 1'b0;

    always @(negedge clk) begin
        if (wr_stb) begin
            stb_cnt  <= stb_cnt + 1;
            stb_addr <= wr_addr;
            stb_data <= wr_data;
        end
        if (bus_if.sda_oe === 1'b1) oe_high_cnt <= oe_high_cnt + 1;
        if (glitch_en && prev_scl && m_scl && (prev_oe !== bus_if.sda_oe))
            oe_glitch <= oe_glitch + 1;
        prev_scl <= m_scl;
        prev_oe  <= bus_if.sda_oe;
    end

    task automatic qtr();
        repeat (QTR) @(posedge clk);
        #1;
    endtask

    task automatic bus_start();
        m_sda = 1'b1; qtr();
        m_scl = 1'b1; qtr();
        m_sda = 1'b0; qtr();
        m_scl = 1'b0; qtr();
    endtask

    task automatic bus_stop();
        m_sda = 1'b0; qtr();
        m_scl = 1'b1; qtr();
        m_sda = 1'b1; qtr();
    endtask

    task automatic clock_bit(input logic b, output logic seen);
        m_sda = b;    qtr();
        m_scl = 1'b1; qtr();
        seen = bus_if.sda_in;
        qtr();
        m_scl = 1'b0; qtr();
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic dummy;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], dummy);
        clock_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        logic v;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, v);
            d[i] = v;
        end
        clock_bit(mack, v);
    endtask

    task automatic loc_read(input logic [PW-1:0] a, output logic [7:0] d);
        loc_addr = a;
        @(posedge clk); @(posedge clk); #1;
        d = loc_rdata;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        int nz;
        nrst = 1'b0;
        repeat (5) @(posedge clk);
        #1 nrst = 1'b1;
        @(posedge clk); #1;
        total++; if (bus_if.sda_oe !== 1'b0) begin bad++; $display("FAIL reset_oe got=%b exp=0", bus_if.sda_oe); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (wr_stb !== 1'b0) begin bad++; $display("FAIL reset_stb got=%b exp=0", wr_stb); end
        total++; if (wr_addr !== 3'd0 || wr_data !== 8'h00) begin bad++; $display("FAIL reset_wr got=%0h/%0h exp=0/0", wr_addr, wr_data); end
        nz = 0;
        for (int i = 0; i < NREG; i++) begin
            loc_read(i[PW-1:0], d);
            if (d !== 8'h00) nz++;
        end
        total++; if (nz != 0) begin bad++; $display("FAIL reset_regs nonzero=%0d exp=0", nz); end
    endtask

    task automatic test_write_single();
        logic ack;
        logic [7:0] d;
        int s0 = stb_cnt;
        bus_start();
        write_byte(8'hA0, ack);
        total++; if (ack !== 1'b0) begin bad++; $display("FAIL w1_addr_ack got=%b exp=0", ack); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL w1_busy got=%b exp=1", busy); end
        write_byte(8'h03, ack);
        total++; if (ack !== 1'b0) begin bad++; $display("FAIL w1_ptr_ack got=%b exp=0", ack); end
        write_byte(8'hA5, ack);
        total++; if (ack !== 1'b0) begin bad++; $display("FAIL w1_data_ack got=%b exp=0", ack); end
        bus_stop();
        qtr();
        total++; if (stb_cnt - s0 != 1) begin bad++; $display("FAIL w1_stb_count got=%0d exp=1", stb_cnt - s0); end
        total++; if (stb_addr !== 3'd3 || stb_data !== 8'hA5) begin bad++; $display("FAIL w1_stb_val got=%0h/%0h exp=3/a5", stb_addr, stb_data); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL w1_busy_after_stop got=%b exp=0", busy); end
        loc_read(3'd3, d);
        total++; if (d !== 8'hA5) begin bad++; $display("FAIL w1_loc_read got=%0h exp=a5", d); end
    endtask

    task automatic test_wrap();
        logic ack, any_nack;
        logic [7:0] d6, d7, d0;
        any_nack = 1'b0;
        bus_start();
        write_byte(8'hA0, ack); any_nack |= ack;
        write_byte(8'h06, ack); any_nack |= ack;
        write_byte(8'h11, ack); any_nack |= ack;
        write_byte(8'h22, ack); any_nack |= ack;
        write_byte(8'h33, ack); any_nack |= ack;
        bus_stop();
        total++; if (any_nack !== 1'b0) begin bad++; $display("FAIL wrap_acks got=%b exp=0", any_nack); end
        total++; if (stb_addr !== 3'd0) begin bad++; $display("FAIL wrap_last_addr got=%0d exp=0", stb_addr); end
        loc_read(3'd6, d6);
        loc_read(3'd7, d7);
        loc_read(3'd0, d0);
        total++; if ({d6, d7, d0} !== 24'h112233) begin bad++; $display("FAIL wrap_regs got=%0h/%0h/%0h exp=11/22/33", d6, d7, d0); end
    endtask

    task automatic test_read();
        logic ack;
        logic [7:0] b0, b1, b2;
        bus_start();
        write_byte(8'hA0, ack);
        write_byte(8'h06, ack);
        bus_start();
        write_byte(8'hA1, ack);
        total++; if (ack !== 1'b0) begin bad++; $display("FAIL rd_addr_ack got=%b exp=0", ack); end
        read_byte(1'b0, b0);
        read_byte(1'b0, b1);
        read_byte(1'b1, b2);
        total++; if (b0 !== 8'h11) begin bad++; $display("FAIL rd_byte0 got=%0h exp=11", b0); end
        total++; if (b1 !== 8'h22) begin bad++; $display("FAIL rd_byte1 got=%0h exp=22", b1); end
        total++; if (b2 !== 8'h33) begin bad++; $display("FAIL rd_byte2 got=%0h exp=33", b2); end
        total++; if (bus_if.sda_oe !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rd_after_nack oe/busy got=%b/%b exp=0/0", bus_if.sda_oe, busy); end
        bus_stop();
    endtask

    task automatic test_mismatch();
        logic ack;
        int s0 = stb_cnt;
        oe_high_cnt = 0;
        bus_start();
        write_byte(8'hA2, ack);
        total++; if (ack !== 1'b1) begin bad++; $display("FAIL mm_addr_nack got=%b exp=1", ack); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mm_busy got=%b exp=0", busy); end
        write_byte(8'h01, ack);
        write_byte(8'h99, ack);
        bus_stop();
        total++; if (oe_high_cnt != 0) begin bad++; $display("FAIL mm_oe_cycles got=%0d exp=0", oe_high_cnt); end
        total++; if (stb_cnt != s0) begin bad++; $display("FAIL mm_stb got=%0d exp=%0d", stb_cnt, s0); end
    endtask

    task automatic test_stop_partial();
        logic ack, dummy;
        logic [7:0] d;
        logic [4:0] bits;
        int s0 = stb_cnt;
        bits = 5'b01010;
        bus_start();
        write_byte(8'hA0, ack);
        write_byte(8'h03, ack);
        for (int i = 4; i >= 0; i--) clock_bit(bits[i], dummy);
        bus_stop();
        qtr();
        total++; if (stb_cnt != s0) begin bad++; $display("FAIL sp_stb got=%0d exp=%0d", stb_cnt, s0); end
        total++; if (bus_if.sda_oe !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL sp_oe_busy got=%b/%b exp=0/0", bus_if.sda_oe, busy); end
        loc_read(3'd3, d);
        total++; if (d !== 8'hA5) begin bad++; $display("FAIL sp_reg3 got=%0h exp=a5", d); end
    endtask

    task automatic test_back_to_back();
        logic ack;
        logic [7:0] b, d;
        int s0 = stb_cnt;
        bus_start();
        write_byte(8'hA0, ack);
        write_byte(8'h02, ack);
        write_byte(8'h5A, ack);
        bus_stop();
        bus_start();
        write_byte(8'hA0, ack);
        write_byte(8'h02, ack);
        bus_start();
        write_byte(8'hA1, ack);
        read_byte(1'b1, b);
        bus_stop();
        total++; if (b !== 8'h5A) begin bad++; $display("FAIL b2b_read got=%0h exp=5a", b); end
        total++; if (stb_cnt - s0 != 1 || stb_data !== 8'h5A) begin bad++; $display("FAIL b2b_stb got=%0d/%0h exp=1/5a", stb_cnt - s0, stb_data); end
        loc_read(3'd2, d);
        total++; if (d !== 8'h5A) begin bad++; $display("FAIL b2b_reg2 got=%0h exp=5a", d); end
    endtask

    task automatic test_sda_timing();
        total++; if (oe_glitch != 0) begin bad++; $display("FAIL oe_change_scl_high got=%0d exp=0", oe_glitch); end
    endtask

    task automatic test_reset_mid_read();
        logic ack, b;
        logic [7:0] d3, d6;
        bus_start();
        write_byte(8'hA0, ack);
        write_byte(8'h03, ack);
        bus_start();
        write_byte(8'hA1, ack);
        clock_bit(1'b1, b);
        total++; if (b !== 1'b1) begin bad++; $display("FAIL rst_rd_bit7 got=%b exp=1", b); end
        total++; if (bus_if.sda_oe !== 1'b1) begin bad++; $display("FAIL rst_rd_oe_before got=%b exp=1", bus_if.sda_oe); end
        glitch_en = 1'b0;
        m_scl = 1'b1;
        repeat (3) @(posedge clk);
        #2 nrst = 1'b0;
        #1;
        total++; if (bus_if.sda_oe !== 1'b0) begin bad++; $display("FAIL rst_rd_oe_release got=%b exp=0", bus_if.sda_oe); end
        repeat (3) @(posedge clk);
        #1 nrst = 1'b1;
        m_scl = 1'b0; qtr();
        bus_stop();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_rd_busy got=%b exp=0", busy); end
        loc_read(3'd3, d3);
        loc_read(3'd6, d6);
        total++; if (d3 !== 8'h00 || d6 !== 8'h00) begin bad++; $display("FAIL rst_rd_regs got=%0h/%0h exp=0/0", d3, d6); end
    endtask

    initial begin
        test_reset();
        test_write_single();
        test_wrap();
        test_read();
        test_mismatch();
        test_stop_partial();
        test_back_to_back();
        test_sda_timing();
        test_reset_mid_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
